// File: rtl/instr_issuer.sv
// instr_issuer: expands host commands into 64-bit systolic-array controller instruction words.
// Build macro INSTR_PARITY_EN: instruction[0] carries even parity over [63:1] of each issued word.
module instr_issuer #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_opcode,
  input  logic [13:0]        req_addr,
  input  logic [COUNT_W-1:0] req_count,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [31:0]        data_in,
  input  logic               instr_hold,
  output logic [63:0]        instruction,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, OSTREAM} state_t;
  typedef enum logic [1:0] {CLS_SINGLE, CLS_DATA, CLS_OUTBUF, CLS_ILLEGAL} cls_t;

  state_t             state, state_nxt;
  logic [4:0]         op_q, op_nxt;
  logic [13:0]        addr_q, addr_nxt;
  logic [COUNT_W-1:0] rem_q, rem_nxt;
  logic               err_nxt;
  logic [63:0]        word_p0;
  logic               vld_p0;
  logic               accept;

  function automatic cls_t op_class(input logic [4:0] op);
    case (op)
      5'b00001, 5'b00010, 5'b00111, 5'b11111: return CLS_SINGLE;
      5'b00100, 5'b00101:                     return CLS_DATA;
      5'b00011, 5'b00110:                     return CLS_OUTBUF;
      default:                                return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [63:0] add_parity(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef INSTR_PARITY_EN
    r[0] = ^w[63:1];
`endif
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign data_ready = (state == STREAM) && !instr_hold;
  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;

  // Stage p0: command decode, burst bookkeeping and word assembly
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    err_nxt   = 1'b0;
    word_p0   = 64'b0;
    vld_p0    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt = req_opcode;
          case (op_class(req_opcode))
            CLS_SINGLE: begin
              state_nxt = ISSUE;
              addr_nxt  = req_addr;
            end
            CLS_DATA: begin
              state_nxt = STREAM;
              addr_nxt  = req_addr;
              rem_nxt   = req_count;
            end
            CLS_OUTBUF: begin
              state_nxt = OSTREAM;
              addr_nxt  = {10'b0, req_addr[3:0]};
              rem_nxt   = req_count;
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        if (!instr_hold) begin
          vld_p0    = 1'b1;
          word_p0   = {op_q, addr_q, 45'b0};
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (data_valid && data_ready) begin
          vld_p0   = 1'b1;
          word_p0  = {op_q, addr_q, data_in, 13'b0};
          addr_nxt = addr_q + 14'd1;
          if (rem_q == '0) state_nxt = IDLE;
          else             rem_nxt   = rem_q - 1'b1;
        end
      end
      OSTREAM: begin
        if (!instr_hold) begin
          vld_p0   = 1'b1;
          word_p0  = {op_q, 10'b0, addr_q[3:0], 45'b0};
          addr_nxt = {10'b0, addr_q[3:0] + 4'd1};
          if (rem_q == '0) state_nxt = IDLE;
          else             rem_nxt   = rem_q - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= 5'b0;
      addr_q <= 14'b0;
      rem_q  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      addr_q <= addr_nxt;
      rem_q  <= rem_nxt;
      err    <= err_nxt;
    end
  end

  // Stage p1: registered instruction word, zero whenever nothing issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instruction <= 64'b0;
    else        instruction <= vld_p0 ? add_parity(word_p0) : 64'b0;
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios plus a randomized command stream
// compared against a word-list model built from the command rules.
module tb_instr_issuer;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         req_opcode;
  logic [13:0]        req_addr;
  logic [COUNT_W-1:0] req_count;
  logic               data_valid;
  logic               data_ready;
  logic [31:0]        data_in;
  logic               instr_hold;
  logic [63:0]        instruction;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  instr_issuer #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr(req_addr), .req_count(req_count),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .instr_hold(instr_hold), .instruction(instruction),
    .busy(busy), .err(err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  bit          mon_en  = 1'b0;
  int          err_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference word formats
  function automatic logic [63:0] fix_par(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef INSTR_PARITY_EN
    r[0] = ^w[63:1];
`endif
    return r;
  endfunction

  function automatic logic [63:0] w_single(input logic [4:0] op, input logic [13:0] a);
    return fix_par({op, a, 45'b0});
  endfunction

  function automatic logic [63:0] w_data(input logic [4:0] op, input logic [13:0] base,
                                         input int i, input logic [31:0] d);
    logic [13:0] a;
    a = 14'((int'(base) + i) % 16384);
    return fix_par({op, a, d, 13'b0});
  endfunction

  function automatic logic [63:0] w_out(input logic [4:0] op, input logic [13:0] base, input int i);
    logic [3:0] n;
    n = 4'((int'(base) + i) % 16);
    return fix_par({op, 10'b0, n, 45'b0});
  endfunction

  always @(negedge clk) begin
    if (mon_en && instruction !== 64'b0) got_q.push_back(instruction);
    if (mon_en && err === 1'b1) err_seen++;
`ifdef INSTR_PARITY_EN
    if (rst_n === 1'b1 && instruction !== 64'b0)
      check1("parity", instruction[0], ^instruction[63:1]);
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          cls, sel, k, guard, exp_illegal;
  logic [4:0]  op;
  logic [13:0] a;
  logic [7:0]  cnt;
  logic [31:0] pay[$];
  bit          hs;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = 5'b0; req_addr = 14'b0; req_count = '0;
    data_valid = 1'b0; data_in = 32'b0; instr_hold = 1'b0;
    exp_illegal = 0;
    tick();
    check("rst_instr_in_reset", instruction, 64'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_instr", instruction, 64'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_data_ready", data_ready, 1'b0);

    // SINGLE MAC
    req_valid = 1'b1; req_opcode = 5'b00001; req_addr = 14'h0012;
    tick();
    req_valid = 1'b0;
    check1("s_busy", busy, 1'b1);
    check("s_pre", instruction, 64'b0);
    tick();
    check("s_word", instruction, fix_par(64'h0802_4000_0000_0000));
    check1("s_busy_done", busy, 1'b0);
    tick();
    check("s_after", instruction, 64'b0);

    // DATA burst across the address wrap
    req_valid = 1'b1; req_opcode = 5'b00100; req_addr = 14'h3FFE; req_count = 8'd2;
    tick();
    req_valid = 1'b0;
    check1("d_busy", busy, 1'b1);
    check("d_pre", instruction, 64'b0);
    data_valid = 1'b1; data_in = 32'hA1;
    #1;
    check1("d_data_ready", data_ready, 1'b1);
    tick();
    check("d_w0", instruction, w_data(5'b00100, 14'h3FFE, 0, 32'hA1));
    data_in = 32'hB2;
    tick();
    check("d_w1", instruction, w_data(5'b00100, 14'h3FFE, 1, 32'hB2));
    data_in = 32'hC3;
    tick();
    check("d_w2", instruction, w_data(5'b00100, 14'h3FFE, 2, 32'hC3));
    data_valid = 1'b0;
    check1("d_req_ready", req_ready, 1'b1);
    check1("d_idle", busy, 1'b0);
    tick();
    check("d_after", instruction, 64'b0);

    // DATA burst with gaps and a hold cycle
    req_valid = 1'b1; req_opcode = 5'b00101; req_addr = 14'h0100; req_count = 8'd1;
    tick();
    req_valid = 1'b0;
    data_valid = 1'b1; data_in = 32'hD0D0_0001;
    tick();
    check("h_w0", instruction, w_data(5'b00101, 14'h0100, 0, 32'hD0D0_0001));
    data_valid = 1'b0;
    tick();
    check("h_gap1", instruction, 64'b0);
    tick();
    check("h_gap2", instruction, 64'b0);
    data_valid = 1'b1; data_in = 32'hD0D0_0002; instr_hold = 1'b1;
    #1;
    check1("h_ready_hold", data_ready, 1'b0);
    tick();
    check("h_hold", instruction, 64'b0);
    check1("h_busy_hold", busy, 1'b1);
    instr_hold = 1'b0;
    tick();
    check("h_w1", instruction, w_data(5'b00101, 14'h0100, 1, 32'hD0D0_0002));
    data_valid = 1'b0;
    check1("h_idle", busy, 1'b0);
    tick();
    check("h_after", instruction, 64'b0);

    // OUTBUF burst across the nibble wrap
    req_valid = 1'b1; req_opcode = 5'b00110; req_addr = 14'h000E; req_count = 8'd3;
    tick();
    req_valid = 1'b0;
    check("o_pre", instruction, 64'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("o_word", instruction, w_out(5'b00110, 14'h000E, i));
      check("o_hi_zero", {54'b0, instruction[58:49]}, 64'b0);
    end
    check1("o_idle", busy, 1'b0);
    tick();
    check("o_after", instruction, 64'b0);

    // ILLEGAL opcode
    req_valid = 1'b1; req_opcode = 5'b01010; req_addr = 14'h0555; data_valid = 1'b1;
    #1;
    check1("i_req_ready", req_ready, 1'b1);
    check1("i_data_ready_idle", data_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    check1("i_err", err, 1'b1);
    check("i_instr", instruction, 64'b0);
    check1("i_busy", busy, 1'b0);
    tick();
    check1("i_err_clear", err, 1'b0);
    check("i_instr2", instruction, 64'b0);
    data_valid = 1'b0;

    // Asynchronous reset during word 2 of a 5-word burst
    req_valid = 1'b1; req_opcode = 5'b00100; req_addr = 14'h0200; req_count = 8'd4;
    tick();
    req_valid = 1'b0;
    data_valid = 1'b1; data_in = 32'h1111_0000;
    tick();
    check("r_w0", instruction, w_data(5'b00100, 14'h0200, 0, 32'h1111_0000));
    data_in = 32'h1111_0001;
    tick();
    check("r_w1", instruction, w_data(5'b00100, 14'h0200, 1, 32'h1111_0001));
    #2;
    rst_n = 1'b0;
    #1;
    check("r_async_instr", instruction, 64'b0);
    check1("r_async_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check1("r_req_ready", req_ready, 1'b1);
    check1("r_busy", busy, 1'b0);
    check1("r_data_ready", data_ready, 1'b0);
    tick();
    check("r_no_word1", instruction, 64'b0);
    tick();
    check("r_no_word2", instruction, 64'b0);
    data_valid = 1'b0;

    // Randomized command stream against the word-list model
    exp_q.delete();
    got_q.delete();
    err_seen = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0: begin
          sel = $urandom_range(0, 3);
          op = (sel == 0) ? 5'b00001 : (sel == 1) ? 5'b00010 : (sel == 2) ? 5'b00111 : 5'b11111;
        end
        1: op = ($urandom_range(0, 1) == 0) ? 5'b00100 : 5'b00101;
        2: op = ($urandom_range(0, 1) == 0) ? 5'b00011 : 5'b00110;
        default: begin
          sel = $urandom_range(0, 23);
          op = (sel == 0) ? 5'b00000 : 5'(sel + 7);
        end
      endcase
      a = 14'($urandom);
      if ($urandom_range(0, 2) == 0) a = 14'h3FFC + 14'($urandom_range(0, 3));
      cnt = 8'($urandom_range(0, 5));
      pay.delete();
      for (int i = 0; i <= int'(cnt); i++) pay.push_back($urandom);

      case (cls)
        0: exp_q.push_back(w_single(op, a));
        1: for (int i = 0; i <= int'(cnt); i++) exp_q.push_back(w_data(op, a, i, pay[i]));
        2: for (int i = 0; i <= int'(cnt); i++) exp_q.push_back(w_out(op, a, i));
        default: exp_illegal++;
      endcase

      req_valid = 1'b1; req_opcode = op; req_addr = a; req_count = cnt;
      instr_hold = ($urandom_range(0, 3) == 0);
      #1;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      check1("rnd_accept_wait", guard < 20, 1'b1);
      tick();
      req_valid = 1'b0;
      instr_hold = 1'b0;
      guard = 0;
      if (cls == 1) begin
        k = 0;
        while (k <= int'(cnt) && guard < 200) begin
          data_valid = ($urandom_range(0, 3) != 0);
          data_in    = pay[k];
          instr_hold = ($urandom_range(0, 3) == 0);
          #1;
          hs = data_valid && data_ready;
          tick();
          if (hs) k++;
          guard++;
        end
        data_valid = 1'b0;
        instr_hold = 1'b0;
      end else begin
        while (busy === 1'b1 && guard < 200) begin
          instr_hold = ($urandom_range(0, 3) == 0);
          tick();
          guard++;
        end
        instr_hold = 1'b0;
      end
      check1("rnd_done_bound", guard < 200, 1'b1);
      check1("rnd_idle", busy, 1'b0);
      tick();
    end
    tick();
    tick();
    mon_en = 1'b0;

    check("rnd_word_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rnd_word", got_q[i], exp_q[i]);
    check("rnd_err_count", 64'(err_seen), 64'(exp_illegal));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Host-side sequencer that generates the 64-bit instruction words consumed by the systolic-array controller.
- Accepts high-level commands over a valid/ready request port, plus a 32-bit data stream.
- Expands each command into one or more single-cycle instruction words.
- Packs the words in the controller's format: opcode [63:59], address [58:45], data [44:13], [12:0] reserved (zero).

Parameters:
COUNT_W, 8, width of the burst-length field; a burst issues req_count+1 instructions (1..2^COUNT_W).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command request valid
req_ready  output  1  command accepted when valid&ready
req_opcode  input  5  controller opcode to issue
req_addr  input  14  start address
req_count  input  COUNT_W  burst length minus one
data_valid  input  1  payload word valid
data_ready  output  1  payload word consumed when valid&ready
data_in  input  32  payload word
instr_hold  input  1  downstream stall; pauses issue
instruction  output  64  registered instruction word to controller
busy  output  1  state != IDLE
err  output  1  one-cycle pulse on illegal opcode

Behaviour:
- Reset values: instruction=64'b0, err=0, state=IDLE, busy=0, internal counters=0.
- req_ready=(state==IDLE) and data_ready are combinational.
- Reset is asynchronous. Asserting it mid-burst returns the block to IDLE, discards remaining work, and zeroes instruction immediately.
- instruction is registered. Each issued word is driven for exactly one cycle; every other cycle drives 64'b0 (opcode 00000, "no instruction"). A word is never repeated.
- Command classes, latched on req_valid&req_ready:
  - SINGLE: 00001 MAC, 00010 send weights, 00111 reset accum, 11111 NOP. Next state ISSUE. ISSUE emits {op, addr, 32'b0, 13'b0} on the next edge where instr_hold=0, then returns to IDLE.
  - DATA burst: 00100 receive inputs, 00101 receive weights. Next state STREAM; remaining=req_count, cur_addr=req_addr.
    - In STREAM, data_ready=!instr_hold.
    - Each data_valid&data_ready emits {op, cur_addr, data_in, 13'b0} next cycle.
    - cur_addr increments mod 2^14 (wraps 3FFF->0000).
    - When remaining==0 at the handshake, go to IDLE; otherwise decrement.
    - A cycle with no data emits 64'b0 and leaves the counters unchanged.
  - OUTBUF burst: 00011 store output, 00110 transmit output. Next state OSTREAM; cur_addr = req_addr[3:0] zero-extended.
    - Emits one word per cycle while instr_hold=0: {op, 10'b0, cur_addr[3:0], 32'b0, 13'b0}.
    - Low nibble wraps F->0.
    - Terminates like a DATA burst.
  - ILLEGAL: 00000, 01000..11110. Accepted, no word emitted, err=1 for one cycle, stays IDLE.
- instr_hold=1: no word issued (instruction=0), data_ready=0, counters and state frozen. Hold does not block command acceptance in IDLE.
- Latency: command acceptance to first word is 1 cycle, absent hold and with data available.
- Throughput: 1 word/cycle in bursts. Back-to-back SINGLE commands issue 1 word per 2 cycles.
- data_valid outside STREAM is ignored (data_ready=0).
- The final burst word and the next command's acceptance cannot overlap, because req_ready only rises in IDLE.

Optional Feature:
- Macro INSTR_PARITY_EN.
  - Defined: instruction[0] carries even parity over instruction[63:1] for every issued word. Idle words stay all-zero (parity 0).
  - Undefined: instruction[12:0] is always zero.

Test Plan:
- Reset, then SINGLE op=00001, addr=0x0012: one cycle later instruction=0x0802_4000_0000_0000 for exactly 1 cycle, then 0; busy high for 1 cycle.
- DATA op=00100, addr=0x3FFE, count=2, data A1,B2,C3 on consecutive cycles: three words with addresses 3FFE, 3FFF, 0000 carrying A1, B2, C3; IDLE afterwards; req_ready reasserts.
- DATA op=00101, count=1, data_valid low for 2 cycles between words and instr_hold=1 for 1 cycle: instruction=0 during gaps; no data consumed under hold; exactly 2 words issued.
- OUTBUF op=00110, addr=0x000E, count=3: addresses E, F, 0, 1 on 4 consecutive cycles; bits [58:49]=0.
- op=01010: accepted; err=1 one cycle; instruction stays 0; busy stays 0.
- Assert rst_n=0 during word 2 of a 5-word DATA burst: instruction=0 asynchronously; after release, state is IDLE with req_ready=1 and no further words issued. With INSTR_PARITY_EN defined, check bit 0 equals XOR of bits [63:1] for every issued word.
